// File: rtl/fsm_pp_pkg.sv
// rtl/fsm_pp_pkg.sv - shared widths, trace FSM states and snapshot field offsets (FSM_TRACE_TS_EN adds ts field)
package fsm_pp_pkg;

   localparam int ST_W   = 2;
   localparam int SNAP_W = 3 * ST_W;

   // Offsets of each state group inside the snapshot, above any ts field
   localparam int OFF_DATA = 0;
   localparam int OFF_ADDR = ST_W;
   localparam int OFF_REG  = 2 * ST_W;

`ifdef FSM_TRACE_TS_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      AVAIL = 2'd1,
      FULL  = 2'd2
   } trace_state_t;

endpackage

// File: rtl/fsm_trace_buf.sv
// rtl/fsm_trace_buf.sv - DEPTH x WIDTH first-word-fall-through snapshot FIFO
module fsm_trace_buf #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Extra pointer MSB distinguishes full from empty when the low bits match
   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == (AW + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fsm_trace_capture.sv
// rtl/fsm_trace_capture.sv - snapshots state bits on status rising edges into a drained FIFO; FSM_TRACE_TS_EN adds a timestamp
module fsm_trace_capture
   import fsm_pp_pkg::*;
#(
   parameter  int DEPTH    = 4,
   parameter  int TS_WIDTH = 8,
   parameter  int DROP_W   = 4,
   localparam int ENTRY_W  = SNAP_W + (TS_EN ? TS_WIDTH : 0)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ST_W-1:0]     st_reg,
   input  logic [ST_W-1:0]     st_addr,
   input  logic [ST_W-1:0]     st_data,
   input  logic                status,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ENTRY_W-1:0]  out_entry,
   output logic [DROP_W-1:0]   drop_cnt,
   input  logic                clr_drop
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic               status_q;
   logic               cap;
   logic               pop;
   logic               push;
   logic               drop;
   logic               full;
   logic               empty;
   logic [CW-1:0]      count;
   logic [ENTRY_W-1:0] snap;
   trace_state_t       state;
   trace_state_t       state_nxt;

   assign cap  = status & ~status_q;
   assign pop  = out_valid & out_ready;
   // A full FIFO still accepts a capture when the head leaves in the same cycle
   assign push = cap & (~full | pop);
   assign drop = cap & full & ~pop;

`ifdef FSM_TRACE_TS_EN
   logic [TS_WIDTH-1:0] ts;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts <= '0;
      end else begin
         ts <= ts + 1'b1;
      end
   end

   assign snap = {st_reg, st_addr, st_data, ts};
`else
   assign snap = {st_reg, st_addr, st_data};
`endif

   fsm_trace_buf #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .wr_data (snap),
      .rd_data (out_entry),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         status_q <= 1'b0;
         drop_cnt <= '0;
         state    <= IDLE;
      end else begin
         status_q <= status;
         state    <= state_nxt;
         if (clr_drop) begin
            drop_cnt <= '0;
         end else if (drop && !(&drop_cnt)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (push) state_nxt = AVAIL;
         AVAIL: begin
            if (pop && !push && count == CW'(1)) begin
               state_nxt = IDLE;
            end else if (push && !pop && count == CW'(DEPTH - 1)) begin
               state_nxt = FULL;
            end
         end
         FULL:  if (pop && !push) state_nxt = AVAIL;
         default: state_nxt = IDLE;
      endcase
   end

   // Drain side is driven by the FSM; the buffer's empty flag must agree with it
   assign out_valid = (state != IDLE) & ~empty;

endmodule

// File: tb/tb_fsm_trace_capture.sv
// tb/tb_fsm_trace_capture.sv - self-checking bench for fsm_trace_capture
module tb_fsm_trace_capture;

   localparam int DEPTH    = 4;
   localparam int TS_WIDTH = 8;
   localparam int DROP_W   = 4;
`ifdef FSM_TRACE_TS_EN
   localparam int ENTRY_W  = 6 + TS_WIDTH;
`else
   localparam int ENTRY_W  = 6;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [1:0]         st_reg = '0;
   logic [1:0]         st_addr = '0;
   logic [1:0]         st_data = '0;
   logic               status = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [ENTRY_W-1:0] out_entry;
   logic [DROP_W-1:0]  drop_cnt;
   logic               clr_drop = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fsm_trace_capture #(
      .DEPTH    (DEPTH),
      .TS_WIDTH (TS_WIDTH),
      .DROP_W   (DROP_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .st_reg    (st_reg),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .status    (status),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_entry (out_entry),
      .drop_cnt  (drop_cnt),
      .clr_drop  (clr_drop)
   );

   // Reference: a queue of snapshots, a saturating integer and the previous status
   logic [ENTRY_W-1:0] m_q[$];
   int                 m_drop;
   bit                 m_sq;
`ifdef FSM_TRACE_TS_EN
   int unsigned        m_ts;
`endif

   typedef struct {
      bit         status;
      bit         ready;
      bit         clr;
      logic [5:0] snap;
      bit         ev;
      logic [5:0] ee;
      logic [3:0] ed;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_snap(input logic [5:0] s);
      {st_reg, st_addr, st_data} = s;
   endtask

   function automatic void model_edge();
      bit               cap;
      logic [5:0]       s;
      logic [ENTRY_W-1:0] e;
      cap = status && !m_sq;
      s   = {st_reg, st_addr, st_data};
`ifdef FSM_TRACE_TS_EN
      e = {s, m_ts[TS_WIDTH-1:0]};
      m_ts = (m_ts + 1) % (1 << TS_WIDTH);
`else
      e = s;
`endif
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (cap) begin
         if (m_q.size() < DEPTH) m_q.push_back(e);
         else if (m_drop < (1 << DROP_W) - 1) m_drop++;
      end
      if (clr_drop) m_drop = 0;
      m_sq = status;
   endfunction

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic model_check();
      chk("model_valid", out_valid, m_q.size() != 0);
      chk("model_entry", out_entry, (m_q.size() != 0) ? m_q[0] : '0);
      chk("model_drop", drop_cnt, m_drop);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_drop", drop_cnt, 0);
      @(posedge clk);
      #1;
      chk("rst_entry", out_entry, 0);
      reset = 1'b1;
      m_q.delete();
      m_drop = 0;
      m_sq   = 1'b0;
`ifdef FSM_TRACE_TS_EN
      m_ts   = 0;
`endif
   endtask

   function automatic void add(bit s, bit r, bit c, logic [5:0] sn, bit ev, logic [5:0] ee, logic [3:0] ed);
      tbl.push_back('{status: s, ready: r, clr: c, snap: sn, ev: ev, ee: ee, ed: ed});
   endfunction

   initial begin
      // Reset with status already high, released with st = 3/1/0
      status = 1'b1;
      set_snap(6'b11_01_00);
      do_reset();
      cycle();
      chk("rel_valid", out_valid, 1);
      chk("rel_entry", out_entry[ENTRY_W-1 -: 6], 6'b11_01_00);

      // Held status, stable head, pulses into a full FIFO, coincident push/pop, clear
      for (int i = 0; i < 4; i++) add(1, 0, 0, 6'(i * 9), 1, 6'h34, 0);
      add(0, 1, 0, 6'h00, 0, 6'h00, 0);
      add(0, 0, 0, 6'h00, 0, 6'h00, 0);
      for (int k = 1; k <= 6; k++) begin
         add(1, 0, 0, 6'(k), 1, 6'h01, 4'((k >= 5) ? k - 4 : 0));
         add(0, 0, 0, 6'h00, 1, 6'h01, 4'((k >= 5) ? k - 4 : 0));
      end
      add(1, 1, 0, 6'h07, 1, 6'h02, 2);
      add(0, 1, 0, 6'h00, 1, 6'h03, 2);
      add(0, 1, 0, 6'h00, 1, 6'h04, 2);
      add(0, 1, 0, 6'h00, 1, 6'h07, 2);
      add(0, 1, 0, 6'h00, 0, 6'h00, 2);
      add(0, 0, 1, 6'h00, 0, 6'h00, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         status    = tbl[i].status;
         out_ready = tbl[i].ready;
         clr_drop  = tbl[i].clr;
         set_snap(tbl[i].snap);
         cycle();
         chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         chk($sformatf("tbl%0d_entry", i), out_entry[ENTRY_W-1 -: 6], tbl[i].ee);
         chk($sformatf("tbl%0d_drop", i), drop_cnt, tbl[i].ed);
      end
      clr_drop = 1'b0;

      // Saturation: 4 fills then 20 drops, then clear racing a drop
      out_ready = 1'b0;
      for (int i = 0; i < 24; i++) begin
         status = 1'b1;
         set_snap(6'(i));
         cycle();
         status = 1'b0;
         cycle();
      end
      chk("sat_drop", drop_cnt, 15);
      model_check();
      status   = 1'b1;
      clr_drop = 1'b1;
      cycle();
      chk("clr_race_drop", drop_cnt, 0);
      chk("clr_race_head", out_entry[ENTRY_W-1 -: 6], 6'h00);
      status   = 1'b0;
      clr_drop = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         model_check();
      end

      // Randomized traffic against the reference, with a reset mid-stream
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            status = 1'b1;
            do_reset();
         end
         status    = $urandom_range(0, 1);
         out_ready = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr_drop  = ($urandom_range(0, 31) == 0);
         set_snap(6'($urandom_range(0, 63)));
         cycle();
         model_check();
      end
      clr_drop = 1'b0;

`ifdef FSM_TRACE_TS_EN
      status    = 1'b0;
      out_ready = 1'b0;
      do_reset();
      for (int c = 0; c <= 265; c++) begin
         status = (c == 3 || c == 260);
         set_snap(6'h2A);
         cycle();
         model_check();
         if (c == 3) chk("ts_first", out_entry[TS_WIDTH-1:0], 3);
      end
      out_ready = 1'b1;
      status    = 1'b0;
      cycle();
      chk("ts_wrapped", out_entry[TS_WIDTH-1:0], 4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
